// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and lane helpers for the load/store memory port.
//   size_e       - request access size (byte, half, word, illegal)
//   state_e      - controller states
//   lane_extract - pick a byte or half lane from a word and sign/zero extend it
//   lane_merge   - insert store data into the selected lane of a word
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_ILL = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_e;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input size_e       size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    r = {{24{b[7] & ~uns}}, b};
      SZ_H:    r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  off,
                                             input size_e       size);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B:    r[{off, 3'b000} +: 8]     = data[7:0];
      SZ_H:    r[{off[1], 4'b0000} +: 16] = data[15:0];
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane handling for the memory port.
//   rd_word     in  word read from memory
//   wdata       in  right-aligned store data
//   off         in  byte offset within the word
//   size        in  access size
//   uns         in  zero-extend instead of sign-extend
//   ext_data    out extended load result
//   merged_data out rd_word with wdata inserted into the addressed lane
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] ext_data,
  output logic [31:0] merged_data
);

  always_comb begin
    ext_data    = lane_extract(rd_word, off, size, uns);
    merged_data = lane_merge(rd_word, wdata, off, size);
  end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: turns byte/half/word load-store requests into word-wide
// memory transactions; sub-word stores are done as read-modify-write.
//   clk, rst                          clock, async active-low reset
//   req_valid/req_ready               request handshake
//   req_we/req_size/req_unsigned      request kind
//   req_addr/req_wdata                byte address, right-aligned store data
//   resp_valid/resp_ready             response handshake
//   resp_rdata/resp_err               extended load data / misalign-illegal flag
//   mem_read/mem_write/mem_addr       memory strobes and word-aligned address
//   mem_wdata/mem_data                memory write and read data
//
// state  | meaning
// IDLE   | ready for a request
// RD     | load read, waiting READ_LATENCY cycles for mem_data
// RMW_RD | read half of a sub-word store
// WR     | single-cycle memory write
// RESP   | response presented until resp_ready
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_data
);

  // Counter holds the remaining read cycles minus one; capture happens at 0.
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        cnt_q, cnt_d;

  logic [31:0]       ext_data;
  logic [31:0]       merged_data;
  logic              req_bad;

  lsu_lane_align u_align (
    .rd_word     (mem_data),
    .wdata       (wdata_q),
    .off         (addr_q[1:0]),
    .size        (size_q),
    .uns         (uns_q),
    .ext_data    (ext_data),
    .merged_data (merged_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    req_bad = (req_size == 2'd3)
            | ((req_size == 2'd1) & req_addr[0])
            | ((req_size == 2'd2) & (|req_addr[1:0]));
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = size_e'(req_size);
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = CNT_INIT;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!req_we) begin
            state_d = RD;
          end else if (req_size == 2'd2) begin
            mem_wdata_d = req_wdata;
            state_d     = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD: begin
        if (cnt_q == 2'd0) begin
          rdata_d = ext_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RMW_RD: begin
        if (cnt_q == 2'd0) begin
          mem_wdata_d = merged_data;
          state_d     = WR;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      WR:      state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_read   = (state_q == RD) || (state_q == RMW_RD);
    mem_write  = (state_q == WR);
    mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wdata  = mem_wdata_q;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Initiator side of the Memory interface (mem_read / mem_write / addr / write_data / mem_data).
- Converts byte, halfword and word load/store requests from the core into word-wide Memory transactions.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Sits between the core's load/store stage and the Memory instance.

Parameters:
- READ_LATENCY, 1, cycles from mem_read asserted to mem_data valid. Legal range 1..4.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned or illegal-size request
- mem_read  out  1  Memory read strobe
- mem_write  out  1  Memory write strobe
- mem_addr  out  ADDR_W  word-aligned address, {req_addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  Memory write data
- mem_data  in  32  Memory read data

Behaviour:
- Reset (rst=0, async): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0.
- Deassertion of rst takes effect at the next clk edge.
- req_ready=1 only in IDLE. A request is accepted on a clk edge with req_valid & req_ready.
- All request fields are registered at accept; later input changes are ignored.
- States:
  - IDLE
  - RD: mem_read=1, counter runs READ_LATENCY cycles.
  - RMW_RD: as RD, used by sub-word stores.
  - WR: mem_write=1 for exactly one cycle.
  - RESP: resp_valid=1, held until resp_ready.
- Transitions from IDLE on accept:
  - size==3, or half with addr[0]!=0, or word with addr[1:0]!=0 -> RESP with resp_err=1. No Memory strobe.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RMW_RD.
- RD: mem_data captured on the cycle the counter expires.
  - Lane select: byte = mem_data[8*addr[1:0] +: 8]; half = mem_data[16*addr[1] +: 16].
  - Sign-extend unless req_unsigned; then -> RESP.
- RMW_RD: on capture, merge req_wdata into the selected lane of the read word -> WR with mem_wdata=merged.
- WR: mem_wdata=req_wdata for word stores; after one cycle -> RESP with resp_rdata=0.
- RESP: leaves on resp_valid & resp_ready -> IDLE. resp_rdata/resp_err remain stable while resp_valid=1 and resp_ready=0.
- No back-to-back overlap: the next accept happens at the earliest one cycle after the response handshake.
- mem_read and mem_write are never high in the same cycle. mem_addr is stable throughout RD/RMW_RD/WR.
- Latency (resp_ready held 1), measured as accept edge to first cycle of resp_valid:
  - Load: READ_LATENCY+1 cycles.
  - Word store: 2 cycles.
  - Sub-word store: READ_LATENCY+2 cycles.
  - Error: 1 cycle.
- Reset mid-operation: all strobes drop immediately and the request is discarded. A partially complete RMW never issues its write.
- mem_addr wraps naturally; no bounds checking is done, since address range is the Memory's responsibility.

Decomposition:
- Shared package lsu_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_ILL).
  - state_e enum (IDLE, RD, RMW_RD, WR, RESP).
  - Functions lane_extract(word, off, size, uns) and lane_merge(word, data, off, size).
- One natural sub-module: lsu_lane_align (combinational extract/extend and merge), so the FSM stays pure control.

Test Plan:
- Reset then LW addr=512, Memory word[512]=0x8000_00F0 -> mem_read=1 for 1 cycle at mem_addr=512; resp_rdata=0x8000_00F0, resp_err=0, response 2 cycles after accept.
- SW addr=200 wdata=0xABC, then LW addr=200 -> exactly one mem_write cycle with mem_wdata=0x0000_0ABC; the load returns 0x0000_0ABC.
- Word[200]=0x1122_3344; SB addr=201 wdata=0xEE -> mem_read then mem_write with mem_wdata=0x1122_EE44; no other word is written.
- Word[200]=0x0000_80FF:
  - LB addr=200 -> 0xFFFF_FFFF.
  - LBU addr=200 -> 0x0000_00FF.
  - LH addr=200 -> 0xFFFF_80FF.
  - LHU addr=202 -> 0x0000_0000.
- LW addr=201, SH addr=203 and size=3 -> each returns resp_err=1 after 1 cycle; mem_read and mem_write stay 0 throughout.
- Hold resp_ready=0 for 5 cycles: response stays stable and req_ready=0. Separately, assert rst=0 during RMW_RD of an SB: mem_write never asserts and all outputs return to reset values asynchronously.
